// File: rtl/dphy_lp_pkg.sv
// Shared D-PHY low-power definitions: LP line states, escape/data-type codes,
// transmitter state encoding and the DSI packet-header ECC.
package dphy_lp_pkg;

    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP10 = 2'b10;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    localparam logic [7:0] ESC_LPDT   = 8'hE1;
    localparam logic [5:0] DT_DCS_SW0 = 6'h05;

    typedef enum logic [2:0] {
        IDLE,
        STOP_HOLD,
        ENTRY,
        ESC_CMD,
        DATA,
        EXIT,
        DONE
    } tx_state_e;

    // Spaced-one-hot mark slot for one bit; the following space slot is always LP00.
    function automatic logic [1:0] lp_bit(input logic b);
        return b ? LP10 : LP01;
    endfunction

    function automatic logic [5:0] dsi_ecc24(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13]
             ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14]
             ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15]
             ^ d[18] ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15]
             ^ d[19] ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18]
             ^ d[19] ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17]
             ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
        return p;
    endfunction

endpackage

// File: rtl/lp_dcs_cmd_tx_if.sv
// Handshake between the power-on init sequencer (master) and the LPDT
// command transmitter (slave).
interface lp_dcs_cmd_tx_if;
    logic i_start;
    logic i_state;
    logic o_eoc;
    logic o_busy;
    logic o_start_err;

    modport master (output i_start, i_state, input o_eoc, o_busy, o_start_err);
    modport slave  (input i_start, i_state, output o_eoc, o_busy, o_start_err);
endinterface

// File: rtl/dsi_ecc.sv
// Combinational DSI packet-header Hamming ECC: 24 header bits {D1,D0,DI} in, 6 parity bits out.
module dsi_ecc
    import dphy_lp_pkg::*;
(
    input  logic [23:0] data_i,
    output logic [5:0]  ecc_o
);
    assign ecc_o = dsi_ecc24(data_i);
endmodule

// File: rtl/lp_dcs_cmd_tx.sv
// LPDT escape-mode transmitter: sends one DCS short-write packet on lane 0
// as spaced-one-hot LP states, then pulses end-of-command to the sequencer.
module lp_dcs_cmd_tx
    import dphy_lp_pkg::*;
#(
    parameter int unsigned TLPX     = 10,
    parameter logic [7:0]  CMD_SEL1 = 8'h11,
    parameter logic [7:0]  CMD_SEL0 = 8'h29,
    parameter logic [1:0]  VC       = 2'd0
) (
    input  logic           i_CLK_100MHZ,
    input  logic           i_reset,
    lp_dcs_cmd_tx_if.slave seq_if,
    output logic [1:0]     o_lp0_out,
    output logic           o_lp0_dir
);

    localparam int unsigned   CW       = $clog2(TLPX);
    localparam logic [CW-1:0] CNT_LOAD = CW'(TLPX - 1);

    tx_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       step_q, step_d;
    logic             half_q, half_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [1:0]       lp_q, lp_d;
    logic             start_q;
    logic             err_q, err_d;
    logic [2:0][7:0]  pkt_q, pkt_d;

    logic [5:0]       ecc;
    logic [3:0][7:0]  tx_bytes;
    logic [7:0]       cur_byte, nxt_byte;
    logic [2:0]       nbit;
    logic             trig, busy, slot_end;

    dsi_ecc u_ecc (
        .data_i (pkt_q),
        .ecc_o  (ecc)
    );

    assign tx_bytes = {2'b00, ecc, pkt_q};
    assign cur_byte = tx_bytes[byte_q];
    assign nxt_byte = tx_bytes[byte_q + 2'd1];
    assign nbit     = bit_q + 3'd1;
    assign trig     = seq_if.i_start & ~start_q;
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign slot_end = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = slot_end ? CNT_LOAD : cnt_q - CW'(1);
        step_d  = step_q;
        half_d  = half_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        lp_d    = lp_q;
        pkt_d   = pkt_q;
        err_d   = err_q | (trig & busy);

        case (state_q)
            IDLE: begin
                cnt_d = CNT_LOAD;
                if (trig) begin
                    state_d = STOP_HOLD;
                    lp_d    = LP11;
                    pkt_d   = {8'h00, (seq_if.i_state ? CMD_SEL1 : CMD_SEL0), {VC, DT_DCS_SW0}};
                end
            end
            STOP_HOLD: if (slot_end) begin
                state_d = ENTRY;
                step_d  = '0;
                lp_d    = LP10;
            end
            ENTRY: if (slot_end) begin
                step_d = step_q + 2'd1;
                case (step_q)
                    2'd0:    lp_d = LP00;
                    2'd1:    lp_d = LP01;
                    2'd2:    lp_d = LP00;
                    default: begin
                        state_d = ESC_CMD;
                        half_d  = 1'b0;
                        bit_d   = '0;
                        lp_d    = lp_bit(ESC_LPDT[7]);
                    end
                endcase
            end
            // Escape code goes MSB first: index 7-n is ~n for a 3-bit n.
            ESC_CMD: if (slot_end) begin
                half_d = ~half_q;
                if (!half_q) begin
                    lp_d = LP00;
                end else if (bit_q == 3'd7) begin
                    state_d = DATA;
                    bit_d   = '0;
                    byte_d  = '0;
                    lp_d    = lp_bit(tx_bytes[0][0]);
                end else begin
                    bit_d = nbit;
                    lp_d  = lp_bit(ESC_LPDT[~nbit]);
                end
            end
            DATA: if (slot_end) begin
                half_d = ~half_q;
                bit_d  = half_q ? nbit : bit_q;
                if (!half_q) begin
                    lp_d = LP00;
                end else if (bit_q == 3'd7 && byte_q == 2'd3) begin
                    state_d = EXIT;
                    step_d  = '0;
                    lp_d    = LP10;
                end else if (bit_q == 3'd7) begin
                    byte_d = byte_q + 2'd1;
                    lp_d   = lp_bit(nxt_byte[0]);
                end else begin
                    lp_d = lp_bit(cur_byte[nbit]);
                end
            end
            EXIT: if (slot_end) begin
                lp_d   = LP11;
                step_d = step_q + 2'd1;
                if (step_q != '0) state_d = DONE;
            end
            DONE: begin
                cnt_d   = CNT_LOAD;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK_100MHZ) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= CNT_LOAD;
            step_q  <= '0;
            half_q  <= 1'b0;
            bit_q   <= '0;
            byte_q  <= '0;
            lp_q    <= LP11;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            lp_q    <= lp_d;
            start_q <= seq_if.i_start;
            err_q   <= err_d;
            pkt_q   <= pkt_d;
        end
    end

    assign seq_if.o_busy      = busy;
    assign seq_if.o_eoc       = (state_q == DONE);
    assign seq_if.o_start_err = err_q;
    assign o_lp0_out          = lp_q;
    assign o_lp0_dir          = 1'b1;

endmodule

// File: tb/tb_lp_dcs_cmd_tx.sv
// Bench for lp_dcs_cmd_tx: one lane at TLPX=10 and one at TLPX=2, LP-line
// decoder feeding a byte scoreboard, plus busy/eoc/start_err checks.
module tb_lp_dcs_cmd_tx;
    import dphy_lp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] start_r;
    logic [1:0] state_r;
    logic [1:0] lp_w   [2];
    logic       dir_w  [2];
    logic       busy_w [2];
    logic       eoc_w  [2];
    logic       err_w  [2];

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned eoc_cnt [2] = '{0, 0};
    int unsigned pkt_cnt [2] = '{0, 0};
    logic [7:0]  exp_q0 [$];
    logic [7:0]  exp_q1 [$];

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pkt(input int lane, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        if (lane == 0) begin
            exp_q0.push_back(b0); exp_q0.push_back(b1); exp_q0.push_back(b2); exp_q0.push_back(b3);
        end else begin
            exp_q1.push_back(b0); exp_q1.push_back(b1); exp_q1.push_back(b2); exp_q1.push_back(b3);
        end
    endtask

    function automatic logic [7:0] pop_exp(input int lane);
        if (lane == 0) return (exp_q0.size() > 0) ? exp_q0.pop_front() : 8'hxx;
        return (exp_q1.size() > 0) ? exp_q1.pop_front() : 8'hxx;
    endfunction

    // s holds every non-LP11 slot of one packet: 4 entry, 40 bit pairs, exit mark.
    task automatic decode_pkt(input int lane, input logic [1:0] s[$], input int unsigned bad_w);
        logic [39:0] bits;
        logic [7:0]  esc, got, exp;
        int unsigned bad_enc;
        check_eq($sformatf("L%0d slot_width", lane), bad_w, 0);
        check_eq($sformatf("L%0d slot_count", lane), s.size(), 85);
        if (s.size() == 85) begin
            check_eq($sformatf("L%0d entry", lane), 32'({s[0], s[1], s[2], s[3]}), 32'(8'b10_00_01_00));
            bad_enc = 0;
            bits    = '0;
            for (int k = 0; k < 40; k++) begin
                if (s[5+2*k] != LP00 || (s[4+2*k] != LP10 && s[4+2*k] != LP01)) bad_enc++;
                bits[k] = (s[4+2*k] == LP10);
            end
            check_eq($sformatf("L%0d bit_enc", lane), bad_enc, 0);
            check_eq($sformatf("L%0d exit_mark", lane), 32'(s[84]), 32'(2'b10));
            for (int k = 0; k < 8; k++) esc[7-k] = bits[k];
            check_eq($sformatf("L%0d esc", lane), 32'(esc), 32'(8'hE1));
            for (int b = 0; b < 4; b++) begin
                for (int i = 0; i < 8; i++) got[i] = bits[8+8*b+i];
                exp = pop_exp(lane);
                check_eq($sformatf("L%0d byte%0d", lane, b), 32'(got), 32'(exp));
            end
        end
        pkt_cnt[lane]++;
    endtask

    for (genvar g = 0; g < 2; g++) begin : ln
        localparam int unsigned T = (g == 0) ? 10 : 2;

        lp_dcs_cmd_tx_if sif ();
        assign sif.i_start = start_r[g];
        assign sif.i_state = state_r[g];
        assign busy_w[g]   = sif.o_busy;
        assign eoc_w[g]    = sif.o_eoc;
        assign err_w[g]    = sif.o_start_err;

        lp_dcs_cmd_tx #(.TLPX(T)) dut (
            .i_CLK_100MHZ (clk),
            .i_reset      (rst),
            .seq_if       (sif),
            .o_lp0_out    (lp_w[g]),
            .o_lp0_dir    (dir_w[g])
        );

        initial begin : mon
            logic [1:0]  prev_lp;
            logic [1:0]  slots [$];
            int unsigned run, bad_w, busy_cnt;
            bit          in_pkt, prev_busy;
            prev_lp = LP11; run = 0; bad_w = 0; busy_cnt = 0; in_pkt = 0; prev_busy = 0;
            forever begin
                @(negedge clk);
                if (eoc_w[g]) eoc_cnt[g]++;
                if (rst) begin
                    prev_lp = LP11; run = 0; in_pkt = 0; busy_cnt = 0; prev_busy = 0;
                    slots.delete();
                end else begin
                    if (lp_w[g] != prev_lp) begin
                        if (in_pkt && prev_lp != LP11) begin
                            slots.push_back(prev_lp);
                            if (run != T) bad_w++;
                        end
                        if (!in_pkt && prev_lp == LP11 && lp_w[g] == LP10) begin
                            in_pkt = 1; bad_w = 0;
                            slots.delete();
                        end else if (in_pkt && lp_w[g] == LP11) begin
                            decode_pkt(g, slots, bad_w);
                            in_pkt = 0;
                        end
                        run = 1;
                    end else begin
                        run++;
                    end
                    prev_lp = lp_w[g];
                    if (busy_w[g]) begin
                        busy_cnt++;
                    end else if (prev_busy) begin
                        check_eq($sformatf("L%0d busy_len", g), busy_cnt, 87 * T);
                        check_eq($sformatf("L%0d eoc_at_busy_fall", g), 32'(eoc_w[g]), 32'(1));
                        busy_cnt = 0;
                    end
                    prev_busy = busy_w[g];
                end
            end
        end
    end

    task automatic wait_eoc(input int lane, input int unsigned target, input int unsigned budget);
        for (int unsigned n = 0; n < budget && eoc_cnt[lane] < target; n++) tick(1);
        check_eq($sformatf("L%0d wait_eoc", lane), eoc_cnt[lane], target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned idle_bad;
        rst = 1'b1; start_r = '0; state_r = '0;
        tick(3);
        for (int l = 0; l < 2; l++) begin
            check_eq($sformatf("L%0d rst_lp", l), 32'(lp_w[l]), 32'(2'b11));
            check_eq($sformatf("L%0d rst_dir", l), 32'(dir_w[l]), 32'(1));
            check_eq($sformatf("L%0d rst_busy", l), 32'(busy_w[l]), 32'(0));
            check_eq($sformatf("L%0d rst_eoc", l), 32'(eoc_w[l]), 32'(0));
            check_eq($sformatf("L%0d rst_err", l), 32'(err_w[l]), 32'(0));
        end
        rst = 1'b0;
        tick(2);

        // exit sleep on both lanes; start level then held high
        expect_pkt(0, 8'h05, 8'h11, 8'h00, 8'h36);
        expect_pkt(1, 8'h05, 8'h11, 8'h00, 8'h36);
        state_r = 2'b11; start_r = 2'b11;
        check_eq("busy_before_edge", 32'(busy_w[0]), 32'(0));
        tick(1);
        check_eq("busy_after_edge", 32'(busy_w[0]), 32'(1));
        wait_eoc(1, 1, 400);
        wait_eoc(0, 1, 1200);
        idle_bad = 0;
        repeat (2000) begin
            tick(1);
            if (lp_w[0] != LP11 || busy_w[0]) idle_bad++;
        end
        check_eq("held_start_idle", idle_bad, 0);
        check_eq("held_start_eoc0", eoc_cnt[0], 1);
        check_eq("held_start_eoc1", eoc_cnt[1], 1);
        check_eq("held_start_err", 32'(err_w[0]), 32'(0));
        start_r = 2'b00;
        tick(2);

        // display on
        expect_pkt(0, 8'h05, 8'h29, 8'h00, 8'h1C);
        state_r[0] = 1'b0; start_r[0] = 1'b1;
        wait_eoc(0, 2, 1200);
        start_r[0] = 1'b0;
        tick(2);

        // second edge mid-packet
        expect_pkt(0, 8'h05, 8'h11, 8'h00, 8'h36);
        state_r[0] = 1'b1; start_r[0] = 1'b1;
        tick(300);
        start_r[0] = 1'b0; tick(1);
        start_r[0] = 1'b1; tick(1);
        check_eq("start_err_set", 32'(err_w[0]), 32'(1));
        wait_eoc(0, 3, 1200);
        tick(20);
        check_eq("start_err_sticky", 32'(err_w[0]), 32'(1));
        check_eq("single_eoc", eoc_cnt[0], 3);
        check_eq("pkt_count3", pkt_cnt[0], 3);
        start_r[0] = 1'b0;
        tick(2);

        // reset mid-packet, then a fresh packet
        start_r[0] = 1'b1;
        tick(400);
        rst = 1'b1; start_r[0] = 1'b0;
        tick(1);
        check_eq("midrst_lp", 32'(lp_w[0]), 32'(2'b11));
        check_eq("midrst_busy", 32'(busy_w[0]), 32'(0));
        check_eq("midrst_err", 32'(err_w[0]), 32'(0));
        rst = 1'b0;
        tick(50);
        check_eq("midrst_no_eoc", eoc_cnt[0], 3);
        check_eq("midrst_no_pkt", pkt_cnt[0], 3);
        expect_pkt(0, 8'h05, 8'h11, 8'h00, 8'h36);
        start_r[0] = 1'b1;
        wait_eoc(0, 4, 1200);
        tick(5);
        check_eq("pkt_count4", pkt_cnt[0], 4);
        check_eq("sb_left0", exp_q0.size(), 0);
        check_eq("sb_left1", exp_q1.size(), 0);
        check_eq("L1_eoc_total", eoc_cnt[1], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
